// File: rtl/ram_arbiter.sv
// Two-requester (CPU / debug) arbiter for a single-port synchronous RAM, with a debug lock.
// Grant is combinational in the request cycle; read data returns one cycle later. Ungranted requests stall.
// A loser or a CPU parked by the lock must hold its request. Optional RAM_ARB_PERF_EN adds a CPU stall counter.
module ram_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_locked,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_w_en,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_ARB_PERF_EN
    ,
    output logic [15:0]       cpu_stall_cnt
`endif
);

    typedef enum logic {NORMAL = 1'b0, LOCKED = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              last_dbg;     // 1: debug owned the last granted access
    logic              pend_cpu, pend_dbg;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    always_comb begin
        state_d = state_q;
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst) begin
            state_d = NORMAL;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (cpu_req && dbg_req) begin
                        if (FIXED_PRIO != 0 || !last_dbg) dbg_gnt = 1'b1;
                        else                              cpu_gnt = 1'b1;
                    end else begin
                        cpu_gnt = cpu_req;
                        dbg_gnt = dbg_req;
                    end
                    if (dbg_lock) state_d = LOCKED;
                end
                LOCKED: begin
                    dbg_gnt = dbg_req;
                    if (!dbg_lock) state_d = NORMAL;
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    // Without a grant the address bus keeps its last value so the RAM pins stay quiet.
    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_w_en  = 1'b0;
        if (cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_w_en  = cpu_we;
        end else if (dbg_gnt) begin
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
            ram_w_en  = dbg_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NORMAL;
            last_dbg <= 1'b1;
            pend_cpu <= 1'b0;
            pend_dbg <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            if (cpu_gnt)      last_dbg <= 1'b0;
            else if (dbg_gnt) last_dbg <= 1'b1;
            pend_cpu <= cpu_gnt & ~cpu_we;
            pend_dbg <= dbg_gnt & ~dbg_we;
            addr_q   <= ram_addr;
            wdata_q  <= ram_wdata;
        end
    end

    // Masking with rst drops a read whose data would land during reset.
    assign cpu_rvalid = pend_cpu & ~rst;
    assign dbg_rvalid = pend_dbg & ~rst;
    assign cpu_rdata  = ram_rdata;
    assign dbg_rdata  = ram_rdata;
    assign dbg_locked = (state_q == LOCKED);

`ifdef RAM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            cpu_stall_cnt <= '0;
        else if (cpu_req && !cpu_gnt && cpu_stall_cnt != 16'hFFFF)
            cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 256x16 synchronous RAM between two requesters: the CPU controller/datapath (instruction fetch, LDR/STR) and a debug/loader port (program load, memory inspection).
- Grants at most one access per cycle using round-robin.
- Supports a debug lock that parks the CPU off the RAM while the loader runs.
- Sits between the controller's memory interface (address select, ram write enable) and the RAM macro.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- FIXED_PRIO, 0. 0 selects round-robin; 1 makes debug always win contention outside lock.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- cpu_rvalid  out  1  read data for CPU valid this cycle
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req  in  1  debug request, held until granted
- dbg_we  in  1  1=write, 0=read
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_lock  in  1  request exclusive RAM ownership
- dbg_gnt  out  1  debug access accepted this cycle (combinational)
- dbg_rvalid  out  1  read data for debug valid
- dbg_rdata  out  DATA_W  debug read data
- dbg_locked  out  1  arbiter is in LOCKED state
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_w_en  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data, one cycle after address

Behaviour:
- State machine with two states:
  - NORMAL: round-robin between requesters.
  - LOCKED: debug exclusive; cpu_gnt forced 0.
- Transitions:
  - NORMAL -> LOCKED on a clock edge where dbg_lock=1.
  - LOCKED -> NORMAL on a clock edge where dbg_lock=0.
  - The cycle in which dbg_lock first rises still arbitrates as NORMAL.
- Registered last_owner (CPU/DBG), used for arbitration in NORMAL:
  - Only one requester asserted: that requester is granted.
  - Both asserted: the requester that is not last_owner is granted; last_owner updates to the granted side on the clock edge.
  - FIXED_PRIO=1: debug always wins; last_owner is still tracked.
- Grant is combinational in the request cycle:
  - ram_addr, ram_wdata and ram_w_en are driven from the granted requester.
  - ram_w_en = gnt & we.
- No grant in a cycle: ram_w_en=0 and ram_addr holds its previous registered value (no toggling).
- Read completion:
  - A granted read sets a one-cycle pending tag (owner).
  - The next cycle, the owner's rvalid=1.
  - cpu_rdata and dbg_rdata both equal ram_rdata; only rvalid qualifies them.
  - Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. A read pending from cycle N coexists with a new grant in cycle N+1.
- Requests not granted stall; the requester must hold req/we/addr/wdata stable.
- Reset values: state=NORMAL, last_owner=DBG (so the CPU wins the first contention), pending tag cleared, cpu_rvalid=dbg_rvalid=0, dbg_locked=0, ram_addr=0.
  - Grants and ram_w_en are 0 while rst=1.
- Reset during an outstanding read: the read is dropped and no rvalid is issued the following cycle.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- Defined:
  - Adds output port cpu_stall_cnt, width 16.
  - Counts cycles with cpu_req=1 and cpu_gnt=0.
  - Saturates at 16'hFFFF; cleared by rst.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Read, CPU alone: after reset, cpu_req=1, cpu_we=0, cpu_addr=8'h05, RAM[5]=16'hBEEF -> cpu_gnt=1 same cycle, ram_addr=8'h05; next cycle cpu_rvalid=1, cpu_rdata=16'hBEEF, dbg_rvalid=0.
- Contention: both requesters read continuously from reset -> grants alternate CPU, DBG, CPU, DBG. Each rvalid trails its grant by exactly one cycle; never both gnt in one cycle.
- Write then read: dbg write 16'h1234 to 8'h10 -> ram_w_en=1 for one cycle, no dbg_rvalid. CPU read of 8'h10 afterwards -> cpu_rdata=16'h1234.
- Lock: cpu_req held, dbg_lock raised at cycle T -> CPU still arbitrable in T; from T+1 dbg_locked=1 and cpu_gnt=0. dbg_lock dropped at U -> CPU granted at U+1.
- Reset mid-read: rst=1 the cycle after a CPU read grant -> cpu_rvalid=0 next cycle; state NORMAL; first contention afterwards goes to CPU.
- RAM_ARB_PERF_EN defined: CPU stalled 3 cycles by contention/lock -> cpu_stall_cnt=3. After rst -> 0.
